// File: rtl/spi_apb_arbiter.sv
// spi_apb_arbiter: shares one downstream APB target (the SPI/XIP bridge) between two APB
// initiators: port 0 = instruction fetch, port 1 = load/store. One transfer is in flight at a
// time. The winner's address/control is latched in IDLE and replayed downstream as a fresh
// SETUP/ACCESS pair. The losing port sees pready=0 and so stalls in its access phase.
//
// Ports:
//   clock, reset                : clock, synchronous active-high reset
//   inN_paddr/psel/penable/     : upstream APB requests, N = 0,1
//   inN_pwrite/pprot/pwdata/pstrb
//   inN_pready/prdata/pslverr   : upstream responses, routed only to the granted port
//   out_paddr/pprot/psel/       : downstream APB request, driven from the latched copy
//   out_penable/pwrite/pwdata/pstrb
//   out_pready/prdata/pslverr   : downstream response
//
// Build option: define SPI_ARB_RR_EN for round-robin tie breaking. When it is undefined,
// port 0 wins every tie (fixed priority).
module spi_apb_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in0_paddr,
  input  logic              in0_psel,
  input  logic              in0_penable,
  input  logic              in0_pwrite,
  input  logic [2:0]        in0_pprot,
  input  logic [31:0]       in0_pwdata,
  input  logic [3:0]        in0_pstrb,
  output logic              in0_pready,
  output logic [31:0]       in0_prdata,
  output logic              in0_pslverr,
  input  logic [ADDR_W-1:0] in1_paddr,
  input  logic              in1_psel,
  input  logic              in1_penable,
  input  logic              in1_pwrite,
  input  logic [2:0]        in1_pprot,
  input  logic [31:0]       in1_pwdata,
  input  logic [3:0]        in1_pstrb,
  output logic              in1_pready,
  output logic [31:0]       in1_prdata,
  output logic              in1_pslverr,
  output logic [ADDR_W-1:0] out_paddr,
  output logic [2:0]        out_pprot,
  output logic              out_psel,
  output logic              out_penable,
  output logic              out_pwrite,
  output logic [31:0]       out_pwdata,
  output logic [3:0]        out_pstrb,
  input  logic              out_pready,
  input  logic [31:0]       out_prdata,
  input  logic              out_pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic              win;
  logic              done;

  // penable is irrelevant to arbitration: psel alone marks a request.
  logic unused_penable;
  assign unused_penable = in0_penable ^ in1_penable;

  // Winner among current requesters; only meaningful when at least one psel is high.
`ifdef SPI_ARB_RR_EN
  assign win = (in0_psel && in1_psel) ? ~last_grant_q : in1_psel;
`else
  assign win = ~in0_psel;
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pprot_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    unique case (state_q)
      StIdle: begin
        if (in0_psel || in1_psel) begin
          grant_d  = win;
          paddr_d  = win ? in1_paddr  : in0_paddr;
          pprot_d  = win ? in1_pprot  : in0_pprot;
          pwrite_d = win ? in1_pwrite : in0_pwrite;
          pwdata_d = win ? in1_pwdata : in0_pwdata;
          pstrb_d  = win ? in1_pstrb  : in0_pstrb;
          state_d  = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (out_pready) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done        = (state_q == StAccess) && out_pready;
    out_psel    = (state_q != StIdle);
    out_penable = (state_q == StAccess);
    out_paddr   = paddr_q;
    out_pprot   = pprot_q;
    out_pwrite  = pwrite_q;
    out_pwdata  = pwdata_q;
    out_pstrb   = pstrb_q;
    in0_pready  = done && !grant_q;
    in1_pready  = done && grant_q;
    in0_prdata  = in0_pready ? out_prdata : 32'h0;
    in1_prdata  = in1_pready ? out_prdata : 32'h0;
    in0_pslverr = in0_pready && out_pslverr;
    in1_pslverr = in1_pready && out_pslverr;
  end

endmodule
